// File: rtl/rotation_phase_tracker_pkg.sv
// Shared types and default sizing for the rotor phase path (tracker and frame_manager).
package rotation_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } phase_state_t;

    localparam int ROTATIONAL_RES_DEFAULT = 256;
    localparam int COUNT_WIDTH_DEFAULT    = 24;

endpackage

// File: rtl/rotation_phase_tracker_if.sv
// Phase bundle from rotation_phase_tracker (master) to frame_manager (slave).
interface rotation_phase_tracker_if #(
    parameter int THETA_W     = 8,
    parameter int COUNT_WIDTH = 24
);
    logic [THETA_W-1:0]     theta;
    logic                   theta_step;
    logic                   theta_valid;
    logic [COUNT_WIDTH-1:0] period;
    logic                   period_ready;
    logic                   stalled;

    modport master (
        output theta, theta_step, theta_valid, period, period_ready, stalled
    );

    modport slave (
        input theta, theta_step, theta_valid, period, period_ready, stalled
    );
endinterface

// File: rtl/rotation_phase_tracker_edge_sync.sv
// Two-flop synchroniser for the raw IR pin followed by a rising-edge pulse.
module ir_edge_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic rise
);
    logic meta;
    logic q1;
    logic q2;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta <= 1'b0;
            q1   <= 1'b0;
            q2   <= 1'b0;
        end else begin
            meta <= async_in;
            q1   <= meta;
            q2   <= q1;
        end
    end

    assign rise = q1 & ~q2;
endmodule

// File: rtl/rotation_phase_tracker.sv
// Measures rotor period from IR beam-break edges and interpolates the angle index
// across the following revolution with a divider-free accumulator.
module rotation_phase_tracker
    import rotation_pkg::*;
#(
    parameter int ROTATIONAL_RES = ROTATIONAL_RES_DEFAULT,
    parameter int COUNT_WIDTH    = COUNT_WIDTH_DEFAULT,
    parameter int MIN_PERIOD     = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     ir_tripped,
    rotation_phase_tracker_if.master phase
);
    localparam int THETA_W = $clog2(ROTATIONAL_RES);
    localparam logic [COUNT_WIDTH-1:0] MAX_PERIOD = '1;
    localparam logic [COUNT_WIDTH-1:0] MIN_CNT    = COUNT_WIDTH'(MIN_PERIOD);
    localparam logic [THETA_W-1:0]     THETA_MAX  = '1;
    localparam logic [COUNT_WIDTH:0]   RES_EXT    = (COUNT_WIDTH+1)'(ROTATIONAL_RES);

    phase_state_t           state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] acc;
    logic [THETA_W-1:0]     theta;
    logic                   theta_step;
    logic                   theta_valid;
    logic [COUNT_WIDTH-1:0] period;
    logic                   period_ready;
    logic                   stalled;

    logic                   ir_rise;
    logic                   accept;
    logic [COUNT_WIDTH:0]   acc_sum;
    logic [COUNT_WIDTH:0]   acc_wrap;

    ir_edge_sync u_edge_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (ir_tripped),
        .rise     (ir_rise)
    );

    // Edges inside the lockout window after an accepted edge are bounce.
    assign accept   = ir_rise & ((state == IDLE) | (cnt >= MIN_CNT));
    assign acc_sum  = {1'b0, acc} + RES_EXT;
    assign acc_wrap = acc_sum - {1'b0, period};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            theta        <= '0;
            theta_step   <= 1'b0;
            theta_valid  <= 1'b0;
            period       <= '0;
            period_ready <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            theta_step   <= 1'b0;
            period_ready <= 1'b0;

            if (accept) begin
                cnt <= COUNT_WIDTH'(1);
            end else if (cnt != MAX_PERIOD) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= ARMED;
                        stalled <= 1'b0;
                    end
                end
                ARMED, LOCKED: begin
                    if (accept) begin
                        // A saturated count still relocks, reporting MAX_PERIOD.
                        state        <= LOCKED;
                        period       <= cnt;
                        period_ready <= 1'b1;
                        theta        <= '0;
                        acc          <= '0;
                        theta_step   <= 1'b1;
                        theta_valid  <= 1'b1;
                    end else if (cnt == MAX_PERIOD) begin
                        state       <= IDLE;
                        stalled     <= 1'b1;
                        theta       <= '0;
                        theta_valid <= 1'b0;
                    end else if (state == LOCKED) begin
                        if (acc_sum >= {1'b0, period}) begin
                            acc <= acc_wrap[COUNT_WIDTH-1:0];
                            // Rotor slower than last revolution: park at the last index.
                            if (theta != THETA_MAX) begin
                                theta      <= theta + 1'b1;
                                theta_step <= 1'b1;
                            end
                        end else begin
                            acc <= acc_sum[COUNT_WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign phase.theta        = theta;
    assign phase.theta_step   = theta_step;
    assign phase.theta_valid  = theta_valid;
    assign phase.period       = period;
    assign phase.period_ready = period_ready;
    assign phase.stalled      = stalled;
endmodule

// File: tb/tb_rotation_phase_tracker.sv
// Scoreboard bench: expected output events come from a timing model of accepted edges,
// revolution periods and ceil(j*P/RES) step times; a monitor compares them as they appear.
module tb_rotation_phase_tracker;
    localparam int RES  = 8;
    localparam int CW   = 8;
    localparam int MINP = 16;
    localparam int MAXP = 255;
    localparam int TW   = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic ir_tripped = 1'b0;

    always #5 clk_in = ~clk_in;

    rotation_phase_tracker_if #(.THETA_W(TW), .COUNT_WIDTH(CW)) phase ();

    rotation_phase_tracker #(
        .ROTATIONAL_RES (RES),
        .COUNT_WIDTH    (CW),
        .MIN_PERIOD     (MINP)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .ir_tripped (ir_tripped),
        .phase      (phase)
    );

    typedef struct {
        int cyc;
        bit pr;
        bit ts;
        int theta;
        int period;
        bit valid;
        bit stl;
    } ev_t;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];
    int  rises[$];
    bit  stl_prev = 1'b0;
    ev_t mon_e;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_ev(input int c, input bit pr, input bit ts, input int th,
                           input int per, input bit v, input bit s);
        ev_t e;
        e.cyc = c; e.pr = pr; e.ts = ts; e.theta = th; e.period = per; e.valid = v; e.stl = s;
        exp_q.push_back(e);
    endtask

    // Step j of a revolution locked at L with period P lands at L + ceil(j*P/RES).
    task automatic push_steps(input int lock_t, input int per, input int end_t);
        int t;
        for (int j = 1; j < RES; j++) begin
            t = lock_t + (j * per + RES - 1) / RES;
            if (t < end_t) push_ev(t, 1'b0, 1'b1, j, per, 1'b1, 1'b0);
        end
    endtask

    // Replays the rise list as accept times (pin rise + 3 cycles) and emits expected events.
    task automatic model_run(input int base, output int end_c);
        int st;
        int last_a;
        int lock_t;
        int per;
        int a;
        int s;
        bit stl;
        st = 0; last_a = 0; lock_t = 0; per = 0; stl = 1'b0;
        end_c = base;
        foreach (rises[i]) begin
            a = base + rises[i] + 3;
            end_c = a;
            if (st != 0 && a - last_a > MAXP) begin
                s = last_a + MAXP;
                if (st == 2) push_steps(lock_t, per, s);
                push_ev(s, 1'b0, 1'b0, 0, per, 1'b0, 1'b1);
                st = 0;
                stl = 1'b1;
            end
            if (st == 0) begin
                if (stl) push_ev(a, 1'b0, 1'b0, 0, per, 1'b0, 1'b0);
                stl = 1'b0;
                st = 1;
                last_a = a;
            end else if (a - last_a >= MINP) begin
                if (st == 2) push_steps(lock_t, per, a);
                per = a - last_a;
                push_ev(a, 1'b1, 1'b1, 0, per, 1'b1, 1'b0);
                st = 2;
                lock_t = a;
                last_a = a;
            end
        end
        if (st != 0) begin
            s = last_a + MAXP;
            if (st == 2) push_steps(lock_t, per, s);
            push_ev(s, 1'b0, 1'b0, 0, per, 1'b0, 1'b1);
            end_c = s;
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            stl_prev = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event: event due at cyc %0d (theta %0d period %0d) not seen by cyc %0d",
                         exp_q[0].cyc, exp_q[0].theta, exp_q[0].period, cyc);
                void'(exp_q.pop_front());
            end
            if (phase.period_ready || phase.theta_step || (phase.stalled != stl_prev)) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event at cyc %0d: pr=%0d ts=%0d theta=%0d period=%0d valid=%0d stalled=%0d, expected none",
                             cyc, phase.period_ready, phase.theta_step, phase.theta, phase.period,
                             phase.theta_valid, phase.stalled);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.pr != phase.period_ready || mon_e.ts != phase.theta_step ||
                        mon_e.theta != int'(phase.theta) || mon_e.period != int'(phase.period) ||
                        mon_e.valid != phase.theta_valid || mon_e.stl != phase.stalled) begin
                        fails++;
                        $display("FAIL event_check: got cyc=%0d pr=%0d ts=%0d theta=%0d period=%0d valid=%0d stalled=%0d, expected cyc=%0d pr=%0d ts=%0d theta=%0d period=%0d valid=%0d stalled=%0d",
                                 cyc, phase.period_ready, phase.theta_step, phase.theta, phase.period,
                                 phase.theta_valid, phase.stalled, mon_e.cyc, mon_e.pr, mon_e.ts,
                                 mon_e.theta, mon_e.period, mon_e.valid, mon_e.stl);
                    end
                end
            end
            stl_prev = phase.stalled;
        end
    end

    // Asserts reset between clock edges and checks that every output clears at once.
    task automatic do_reset();
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        chk("rst_theta", int'(phase.theta), 0);
        chk("rst_theta_step", int'(phase.theta_step), 0);
        chk("rst_theta_valid", int'(phase.theta_valid), 0);
        chk("rst_period", int'(phase.period), 0);
        chk("rst_period_ready", int'(phase.period_ready), 0);
        chk("rst_stalled", int'(phase.stalled), 0);
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #3;
        rst_in = 1'b0;
    endtask

    // Plays the rise list (2-cycle pulses, offsets from reset release); abort_rel>0 stops early.
    task automatic run_scenario(input int abort_rel);
        int base;
        int end_c;
        int stop;
        int rel;
        bit hi;
        base = cyc;
        model_run(base, end_c);
        stop = (abort_rel > 0) ? base + abort_rel : end_c + 5;
        while (cyc < stop) begin
            @(posedge clk_in);
            #1;
            rel = cyc - base;
            hi = 1'b0;
            foreach (rises[i]) if (rel == rises[i] || rel == rises[i] + 1) hi = 1'b1;
            ir_tripped = hi;
        end
        ir_tripped = 1'b0;
        if (abort_rel == 0) begin
            @(negedge clk_in);
            #1;
            chk("queue_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        int t;
        int g;
        int th;
        do_reset();

        // Steady 80-cycle rotation with a bounce 5 cycles after an accept, then a 100-cycle slowdown.
        rises = '{10, 90, 95, 170, 250, 350};
        run_scenario(0);

        // Stall after lock (period held at 80), re-arm without period_ready, then relock.
        do_reset();
        rises = '{10, 90, 170, 470, 550};
        run_scenario(0);

        // Reset while locked, then 50-cycle rotation.
        do_reset();
        rises = '{10, 60};
        run_scenario(100);
        chk("locked_valid", int'(phase.theta_valid), 1);
        th = 0;
        for (int j = 1; j < RES; j++) if ((j * 50 + RES - 1) / RES <= 100 - 63) th = j;
        chk("locked_theta", int'(phase.theta), th);
        do_reset();
        rises = '{10, 60, 110};
        run_scenario(0);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            rises.delete();
            t = 10;
            for (int k = 0; k < 8; k++) begin
                rises.push_back(t);
                g = $urandom_range(0, 9);
                if (g < 2)      t += $urandom_range(4, 15);
                else if (g < 8) t += $urandom_range(16, 140);
                else            t += $urandom_range(230, 300);
            end
            run_scenario(0);
        end

        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
